// File: rtl/rf_pkg.sv
// Shared register-file definitions.
// Holds the default address/data widths, the address/data types, the
// write-request record shared by writeback producers, and the holding-slot
// state encoding used by the write-port scheduler.
package rf_pkg;

  localparam int AW = 3;
  localparam int DW = 8;

  typedef logic [AW-1:0] rf_addr_t;
  typedef logic [DW-1:0] rf_data_t;

  typedef struct packed {
    logic     valid;
    rf_addr_t addr;
    rf_data_t data;
  } wr_req_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_HELD  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/reg_wr_sched_if.sv
// Interface bundling the writeback request side and the register-file write
// port side of the write-port scheduler.
//   req_valid/req_addr/req_data : per-requester write presented
//   req_ready                   : per-requester holding slot can take a write
//   wr_en/wr_addr/wr_data       : registered register-file write port
//   pend_mask                   : registers with writes held or issuing
//   idle                        : nothing held and nothing issuing
// Modports: master = requesters + register file, slave = scheduler.
interface reg_wr_sched_if #(
  parameter int NREQ = 3,
  parameter int AW   = rf_pkg::AW,
  parameter int DW   = rf_pkg::DW
);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0][AW-1:0] req_addr;
  logic [NREQ-1:0][DW-1:0] req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [DW-1:0]           wr_data;
  logic [(1<<AW)-1:0]      pend_mask;
  logic                    idle;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wr_en, wr_addr, wr_data, pend_mask, idle
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wr_en, wr_addr, wr_data, pend_mask, idle
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req      in  : request vector
//   ptr      in  : highest-priority index this cycle
//   grant    out : one-hot grant (zero when no request)
//   next_ptr out : index after the granted one, or ptr when nothing granted
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   next_ptr
);

  int   idx;
  logic found;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    // Walk the requesters starting at ptr, wrapping modulo NREQ.
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = (idx == NREQ - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/reg_wr_sched.sv
// Register-file write-port scheduler.
// Holds one pending write per requester and serialises them onto the single
// register-file write port, one per cycle, in round-robin order. Exports a
// pending-register mask so decode can stall reads of in-flight registers.
//   clk, reset : clock, synchronous active-high reset
//   bus        : reg_wr_sched_if.slave (requests, write port, pend_mask, idle)
module reg_wr_sched
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = rf_pkg::AW,
  parameter int DW   = rf_pkg::DW
) (
  input  logic           clk,
  input  logic           reset,
  reg_wr_sched_if.slave  bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  slot_state_t        slot_st_p0  [NREQ];
  slot_state_t        slot_nxt    [NREQ];
  logic [AW-1:0]      slot_addr_p0[NREQ];
  logic [DW-1:0]      slot_data_p0[NREQ];
  logic [NREQ-1:0]    slot_vld;
  logic [PW-1:0]      rr_ptr_p0;
  logic [PW-1:0]      rr_ptr_nxt;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    ready;
  logic [NREQ-1:0]    accept;
  logic [AW-1:0]      gnt_addr;
  logic [DW-1:0]      gnt_data;
  logic               wr_en_p1;
  logic [AW-1:0]      wr_addr_p1;
  logic [DW-1:0]      wr_data_p1;
  logic [(1<<AW)-1:0] pend;

  always_comb begin
    for (int i = 0; i < NREQ; i++) slot_vld[i] = (slot_st_p0[i] == SLOT_HELD);
  end

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req      (slot_vld),
    .ptr      (rr_ptr_p0),
    .grant    (grant),
    .next_ptr (rr_ptr_nxt)
  );

  // A slot being granted this cycle can be refilled at the same edge.
  assign ready  = ~slot_vld | grant;
  assign accept = bus.req_valid & ready;

  // Slot FSM: a reload wins over the grant-clear, so a granted slot that is
  // refilled stays HELD with the new data.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      slot_nxt[i] = slot_st_p0[i];
      if (accept[i])     slot_nxt[i] = SLOT_HELD;
      else if (grant[i]) slot_nxt[i] = SLOT_EMPTY;
    end
  end

  // Grant is one-hot, so OR-ing the masked slots selects the winner.
  always_comb begin
    gnt_addr = '0;
    gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gnt_addr = gnt_addr | slot_addr_p0[i];
        gnt_data = gnt_data | slot_data_p0[i];
      end
    end
  end

  // ---- stage p0: holding slots and round-robin pointer ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) slot_st_p0[i] <= SLOT_EMPTY;
      rr_ptr_p0 <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) slot_st_p0[i] <= slot_nxt[i];
      rr_ptr_p0 <= rr_ptr_nxt;
    end
  end

  // Slot payload is only loaded on a valid accept, so invalid-cycle X never
  // enters and stale payload is never issued without its HELD state.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (accept[i]) begin
        slot_addr_p0[i] <= bus.req_addr[i];
        slot_data_p0[i] <= bus.req_data[i];
      end
    end
  end

  // ---- stage p1: registered register-file write port ----
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      wr_en_p1 <= |grant;
      if (|grant) begin
        wr_addr_p1 <= gnt_addr;
        wr_data_p1 <= gnt_data;
      end
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (slot_vld[i]) pend[slot_addr_p0[i]] = 1'b1;
    end
    if (wr_en_p1) pend[wr_addr_p1] = 1'b1;
  end

  assign bus.req_ready = ready;
  assign bus.wr_en     = wr_en_p1;
  assign bus.wr_addr   = wr_addr_p1;
  assign bus.wr_data   = wr_data_p1;
  assign bus.pend_mask = pend;
  assign bus.idle      = ~(|slot_vld) & ~wr_en_p1;

endmodule
